// File: rtl/adc_scan_scheduler.sv
// Periodic ADC0809 scan scheduler: each period tick walks the latched channel mask in ascending order.
// Optional feature macro SCAN_AVG_EN: convert every channel twice and publish the truncated mean.
module adc_scan_scheduler #(
  parameter int PERIOD  = 2700,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] ch_mask,
  output logic       adc_start,
  output logic [2:0] adc_addr,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  output logic [7:0] result_data,
  output logic [2:0] result_ch,
  output logic       result_valid,
  output logic       scan_done,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  // Handshake: adc_start is a one-cycle request; the driver answers with a one-cycle
  // adc_valid pulse that is only honoured in WAIT. result_valid is a one-cycle strobe
  // with no back-pressure; result_data/result_ch hold until the next strobe.

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_PUBLISH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   per_q, per_d;
  logic [7:0]      mask_q, mask_d;
  logic [2:0]      ch_q, ch_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      res_data_q, res_data_d;
  logic [2:0]      res_ch_q, res_ch_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
`ifdef SCAN_AVG_EN
  logic            pass_q, pass_d;
  logic [7:0]      s0_q, s0_d;
  logic [8:0]      avg_sum;
`endif

  logic       tick;
  logic       scan_go;
  logic       wait_to;
  logic       ch_leave;
  logic       advance;
  logic       nxt_found;
  logic [2:0] nxt_ch;
  logic [2:0] first_ch;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      per_q      <= '0;
      mask_q     <= '0;
      ch_q       <= '0;
      to_q       <= '0;
      res_data_q <= '0;
      res_ch_q   <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef SCAN_AVG_EN
      pass_q     <= 1'b0;
      s0_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      per_q      <= per_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      to_q       <= to_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
`ifdef SCAN_AVG_EN
      pass_q     <= pass_d;
      s0_q       <= s0_d;
`endif
    end
  end

  // Channel selection: lowest set bit of the live mask at scan start, lowest latched bit above current afterwards.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    first_ch  = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) > ch_q)) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(i);
      end
      if (ch_mask[i]) first_ch = 3'(i);
    end
  end

  always_comb begin
    tick     = (per_q == PW'(PERIOD - 1));
    per_d    = tick ? '0 : per_q + PW'(1);
    scan_go  = tick && enable && (|ch_mask);
    wait_to  = (state_q == S_WAIT) && !adc_valid && (to_q == TO_W'(TIMEOUT - 1));
    ch_leave = (state_q == S_PUBLISH) || wait_to;
    advance  = nxt_found && enable;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (scan_go) state_d = S_SETUP;
      S_SETUP:   state_d = enable ? S_START : S_IDLE;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (adc_valid) begin
`ifdef SCAN_AVG_EN
          state_d = pass_q ? S_PUBLISH : S_START;
`else
          state_d = S_PUBLISH;
`endif
        end else if (wait_to) begin
          state_d = advance ? S_SETUP : S_IDLE;
        end
      end
      S_PUBLISH: state_d = advance ? S_SETUP : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mask_d     = mask_q;
    ch_d       = ch_q;
    to_d       = to_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
`ifdef SCAN_AVG_EN
    pass_d     = pass_q;
    s0_d       = s0_q;
    avg_sum    = {1'b0, s0_q} + {1'b0, adc_data};
`endif
    if (!enable) ovr_d = 1'b0;
    else if (tick && (state_q != S_IDLE)) ovr_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (scan_go) begin
          mask_d = ch_mask;
          ch_d   = first_ch;
        end
      end
      S_SETUP: begin
        if (!enable) done_d = 1'b1;
`ifdef SCAN_AVG_EN
        pass_d = 1'b0;
`endif
      end
      S_START: to_d = '0;
      S_WAIT: begin
        to_d = to_q + TO_W'(1);
        if (adc_valid) begin
`ifdef SCAN_AVG_EN
          if (pass_q) begin
            res_data_d = avg_sum[8:1];
            res_ch_d   = ch_q;
          end else begin
            s0_d   = adc_data;
            pass_d = 1'b1;
          end
`else
          res_data_d = adc_data;
          res_ch_d   = ch_q;
`endif
        end
      end
      default: ;
    endcase
    if (ch_leave) begin
      if (advance) ch_d = nxt_ch;
      else done_d = 1'b1;
    end
  end

  always_comb begin
    adc_start    = (state_q == S_START);
    adc_addr     = ch_q;
    result_valid = (state_q == S_PUBLISH);
    result_data  = res_data_q;
    result_ch    = res_ch_q;
    scan_done    = done_q;
    busy         = (state_q != S_IDLE);
    timeout_err  = wait_to;
    overrun      = ovr_q;
    dbg_state    = state_q;
  end

endmodule
